spi_master16: RTL and testbench

Single-channel SPI master that executes the 16-bit transactions issued by the command dispatcher: analog-front-end gain writes, trigger-level writes, and EEPROM read/write/calibration fetches. It sits directly downstream of the command dispatcher. It accepts a word plus a slave-select code on a one-cycle `wrt` strobe, shifts it out MSB-first in SPI mode 0 while capturing MISO, then pulses `done`. The low byte of the received word is presented as `rd_data` (the EEPROM data path).

---
 rtl/spi_master16_if.sv | 20 ++
 rtl/spi_master16.sv | 123 ++++++++++++
 tb/tb_spi_master16.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master16_if.sv
// Command bus between the dispatcher and spi_master16.
// The dispatcher drives the strobe/word; the SPI master returns status and read data.
interface spi_master16_if;
    logic        wrt;
    logic [15:0] cmd;
    logic [2:0]  ss_sel;
    logic        done;
    logic        busy;
    logic [7:0]  rd_data;

    modport master (
        output wrt, cmd, ss_sel,
        input  done, busy, rd_data
    );

    modport slave (
        input  wrt, cmd, ss_sel,
        output done, busy, rd_data
    );
endinterface

// File: rtl/spi_master16.sv
// 16-bit mode-0 SPI master for AFE gain, trigger level and EEPROM accesses.
// MSB-first shift with MISO captured on the last high cycle of each SCLK period.
module spi_master16 #(
    parameter int SCLK_DIV = 32
) (
    input  logic              clk,
    input  logic              rst,
    spi_master16_if.slave     bus,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [4:0]        SS_n
);

    localparam int H  = SCLK_DIV / 2;
    localparam int CW = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] H_LAST = CW'(H - 1);
    localparam logic [CW-1:0] P_LAST = CW'(SCLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        FRONT,
        SHIFT,
        BACK,
        DONE
    } state_t;

    state_t          state;
    state_t          nstate;
    logic [CW-1:0]   hcnt;
    logic [3:0]      bcnt;
    logic [15:0]     shreg;
    logic [2:0]      sel;
    logic [7:0]      rd_q;
    logic            accept;
    logic            active;

    assign accept = bus.wrt && (state == IDLE || state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE: begin
                if (bus.wrt) nstate = FRONT;
            end
            FRONT: begin
                if (hcnt == H_LAST) nstate = SHIFT;
            end
            SHIFT: begin
                if (hcnt == P_LAST && bcnt == 4'd15) nstate = BACK;
            end
            BACK: begin
                if (hcnt == H_LAST) nstate = DONE;
            end
            DONE: begin
                nstate = bus.wrt ? FRONT : IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
            sel   <= '0;
            rd_q  <= '0;
        end else begin
            if (accept) begin
                shreg <= bus.cmd;
                sel   <= bus.ss_sel;
                hcnt  <= '0;
                bcnt  <= '0;
            end else begin
                case (state)
                    FRONT, BACK: begin
                        hcnt <= (hcnt == H_LAST) ? '0 : hcnt + 1'b1;
                    end
                    SHIFT: begin
                        hcnt <= (hcnt == P_LAST) ? '0 : hcnt + 1'b1;
                        if (hcnt == P_LAST) bcnt <= bcnt + 4'd1;
                        // Sampling on the last high cycle and shifting on the
                        // falling edge collapse into one update here.
                        if (hcnt == H_LAST) shreg <= {shreg[14:0], MISO};
                    end
                    default: ;
                endcase
            end
            if (state == BACK && hcnt == H_LAST) rd_q <= shreg[7:0];
        end
    end

    assign active = (state == FRONT) || (state == SHIFT) || (state == BACK);

    always_comb begin
        SCLK        = (state == SHIFT) && (hcnt <= H_LAST);
        MOSI        = shreg[15];
        bus.busy    = active;
        bus.done    = (state == DONE);
        bus.rd_data = rd_q;
        SS_n        = 5'b11111;
        if (active) begin
            case (sel)
                3'd1:    SS_n = 5'b11110;
                3'd2:    SS_n = 5'b11101;
                3'd3:    SS_n = 5'b11011;
                3'd4:    SS_n = 5'b10111;
                3'd5:    SS_n = 5'b01111;
                default: SS_n = 5'b11111;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master16.sv
// Scoreboard bench for spi_master16: slave model, latency, select and read data.
// A second instance with SCLK_DIV=4 runs a MOSI->MISO loopback.
module tb_spi_master16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master16_if ifa ();
    spi_master16_if ifb ();

    logic       sclk_a, mosi_a, miso_a;
    logic [4:0] ss_a;
    logic       sclk_b, mosi_b;
    logic [4:0] ss_b;

    spi_master16 #(.SCLK_DIV(32)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifa.slave),
        .SCLK (sclk_a),
        .MOSI (mosi_a),
        .MISO (miso_a),
        .SS_n (ss_a)
    );

    spi_master16 #(.SCLK_DIV(4)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .bus  (ifb.slave),
        .SCLK (sclk_b),
        .MOSI (mosi_b),
        .MISO (mosi_b),
        .SS_n (ss_b)
    );

    typedef struct {
        int          t0;
        logic [15:0] cmd;
        logic [15:0] resp;
        logic [4:0]  ss;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   spur = 0;
    int   rises = 0;
    int   falls = 0;
    int   ss_ok = 0;
    logic prev = 1'b0;
    logic [15:0] rx = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [4:0] ss_pat(input logic [2:0] s);
        case (s)
            3'd1:    return 5'b11110;
            3'd2:    return 5'b11101;
            3'd3:    return 5'b11011;
            3'd4:    return 5'b10111;
            3'd5:    return 5'b01111;
            default: return 5'b11111;
        endcase
    endfunction

    // Slave model and completion checker, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rises  = 0;
            falls  = 0;
            ss_ok  = 0;
            rx     = '0;
            prev   = 1'b0;
            miso_a = 1'b0;
        end else begin
            if (sclk_a && !prev) begin
                rises++;
                rx = {rx[14:0], mosi_a};
            end
            if (!sclk_a && prev) falls++;
            prev = sclk_a;
            if (ifa.done && ifa.busy) check("done_busy_overlap", 1, 0);
            if (sb.size() > 0 && ifa.busy && ss_a == sb[0].ss) ss_ok++;
            if (ifa.done) begin
                if (sb.size() == 0) begin
                    spur++;
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc - e.t0, 545);
                    check("rd_data", ifa.rd_data, e.resp[7:0]);
                    check("slave_rx", rx, e.cmd);
                    check("sclk_rises", rises, 16);
                    check("ss_active", ss_ok, 544);
                    check("ss_done", ss_a, 5'h1f);
                    check("busy_done", ifa.busy, 0);
                end
                rises = 0;
                falls = 0;
                ss_ok = 0;
            end
            if (sb.size() > 0 && falls < 16) begin
                e = sb[0];
                miso_a = e.resp[4'(15 - falls)];
            end else begin
                miso_a = 1'b0;
            end
        end
    end

    task automatic start(input logic [15:0] c, input logic [2:0] s,
                         input logic [15:0] r);
        exp_t e;
        @(posedge clk);
        #1;
        e.t0   = cyc;
        e.cmd  = c;
        e.resp = r;
        e.ss   = ss_pat(s);
        sb.push_back(e);
        ifa.cmd    = c;
        ifa.ss_sel = s;
        ifa.wrt    = 1'b1;
        @(posedge clk);
        #1;
        ifa.wrt = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && sb.size() > 0; i++) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
    endtask

    initial begin
        exp_t e;
        int   t0;
        rst        = 1'b1;
        ifa.wrt    = 1'b0;
        ifa.cmd    = '0;
        ifa.ss_sel = '0;
        ifb.wrt    = 1'b0;
        ifb.cmd    = '0;
        ifb.ss_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss", ss_a, 5'h1f);
        check("rst_sclk", sclk_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_done", ifa.done, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_rd", ifa.rd_data, 0);
        rst = 1'b0;

        start(16'h4A5C, 3'd5, 16'h0000);
        wait_idle();

        start(16'h0A00, 3'd5, 16'h00A7);
        wait_idle();
        repeat (100) @(posedge clk);
        #1;
        check("rd_hold", ifa.rd_data, 8'hA7);

        start(16'h1234, 3'd0, 16'hBEEF);
        wait_idle();
        start(16'h8001, 3'd7, 16'h5AC3);
        wait_idle();

        // Chain a second access off the done cycle, then poke wrt mid-shift.
        start(16'h0F0F, 3'd1, 16'h3C3C);
        for (int i = 0; i < 700 && !ifa.done; i++) begin
            @(posedge clk);
            #1;
        end
        check("chain_done_seen", ifa.done, 1);
        e.t0   = cyc;
        e.cmd  = 16'h1305;
        e.resp = 16'h00C4;
        e.ss   = ss_pat(3'd2);
        sb.push_back(e);
        ifa.cmd    = 16'h1305;
        ifa.ss_sel = 3'd2;
        ifa.wrt    = 1'b1;
        @(posedge clk);
        #1;
        ifa.wrt = 1'b0;
        check("chain_ss", ss_a, 5'b11101);
        repeat (16 + 3 * 32) @(posedge clk);
        #1;
        ifa.cmd    = 16'hFFFF;
        ifa.ss_sel = 3'd3;
        ifa.wrt    = 1'b1;
        @(posedge clk);
        #1;
        ifa.wrt = 1'b0;
        wait_idle();
        check("chain_rd", ifa.rd_data, 8'hC4);

        // Reset in the middle of bit 7; no completion may follow.
        @(posedge clk);
        #1;
        ifa.cmd    = 16'h7777;
        ifa.ss_sel = 3'd4;
        ifa.wrt    = 1'b1;
        @(posedge clk);
        #1;
        ifa.wrt = 1'b0;
        repeat (16 + 7 * 32 + 8) @(posedge clk);
        #1;
        check("mid_busy", ifa.busy, 1);
        check("mid_ss", ss_a, 5'b10111);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_ss", ss_a, 5'h1f);
        check("mrst_sclk", sclk_a, 0);
        check("mrst_rd", ifa.rd_data, 0);
        check("mrst_busy", ifa.busy, 0);
        check("mrst_done", ifa.done, 0);
        rst = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        check("no_spurious_done", spur, 0);

        // Fast divider, loopback.
        @(posedge clk);
        #1;
        t0         = cyc;
        ifb.cmd    = 16'hFFFF;
        ifb.ss_sel = 3'd1;
        ifb.wrt    = 1'b1;
        @(posedge clk);
        #1;
        ifb.wrt = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ifb.done) break;
            @(posedge clk);
            #1;
        end
        check("b_done_seen", ifb.done, 1);
        check("b_latency", cyc - t0, 69);
        check("b_rd", ifb.rd_data, 8'hFF);
        check("b_ss_done", ss_b, 5'h1f);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
